// File: rtl/cp0_exc_pkg.sv
// Shared constants and types for the CP0 exception responder: ExcCodes, CP0
// register numbers, exception vectors, Status reset value and the FSM state type.
package cp0_exc_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    localparam logic [7:0] EXC_INT  = 8'h00;
    localparam logic [7:0] EXC_ADEL = 8'h04;
    localparam logic [7:0] EXC_ADES = 8'h05;
    localparam logic [7:0] EXC_SYS  = 8'h08;
    localparam logic [7:0] EXC_BP   = 8'h09;
    localparam logic [7:0] EXC_RI   = 8'h0a;
    localparam logic [7:0] EXC_OV   = 8'h0c;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] VEC_BOOT     = 32'hBFC0_0380;
    localparam logic [31:0] VEC_NORMAL   = 32'h8000_0180;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam int          STATUS_BEV   = 22;

    function automatic logic [31:0] exc_vector(input logic bev);
        return bev ? VEC_BOOT : VEC_NORMAL;
    endfunction

    function automatic logic is_addr_err(input logic [7:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_exc_if.sv
// Commit-stage bus between the pipeline (master) and the CP0 exception
// responder (slave): exception/eret requests, mtc0/mfc0 port, flush/redirect.
interface cp0_exc_if;

    logic        exc_valid;
    logic [7:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret_valid;
    logic        mtc0_we;
    logic [4:0]  c0_addr;
    logic [2:0]  c0_sel;
    logic [31:0] mtc0_wdata;
    logic [31:0] mfc0_rdata;
    logic [5:0]  hw_int;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        int_pending;

    modport master (
        output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret_valid,
        output mtc0_we, c0_addr, c0_sel, mtc0_wdata, hw_int,
        input  mfc0_rdata, flush, redirect_pc, int_pending
    );

    modport slave (
        input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret_valid,
        input  mtc0_we, c0_addr, c0_sel, mtc0_wdata, hw_int,
        output mfc0_rdata, flush, redirect_pc, int_pending
    );

endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, TI is raised when
// Count steps onto Compare and cleared by any Compare write.
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic half;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            half    <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            half <= ~half;
            if (count_we) begin
                count <= wdata;
            end else if (half) begin
                count <= count + 32'd1;
            end
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (!count_we && half && (count + 32'd1 == compare)) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc.sv
// CP0 exception responder at the commit stage: Status/Cause/EPC/BadVAddr, flush
// and redirect generation, eret, mtc0/mfc0. Timer built only with CP0_TIMER_EN.
module cp0_exc
    import cp0_exc_pkg::*;
(
    input logic       clk,
    input logic       resetn,
    cp0_exc_if.slave  bus
);

    state_t      state, state_nxt;
    logic        exc_take, eret_take, mtc0_take;
    logic [7:0]  status_im;
    logic        status_exl, status_ie;
    logic        cause_bd;
    logic [4:0]  cause_exc;
    logic [5:0]  cause_hw;
    logic [1:0]  cause_sw;
    logic [7:0]  cause_ip;
    logic [31:0] epc, badvaddr, redirect_q;
    logic [31:0] status_val, cause_val, rdata;
    logic [31:0] count, compare;
    logic        ti;

    // Anything arriving during FLUSH belongs to a squashed instruction.
    assign exc_take  = (state == ST_IDLE) && bus.exc_valid;
    assign eret_take = (state == ST_IDLE) && bus.eret_valid && !bus.exc_valid;
    assign mtc0_take = (state == ST_IDLE) && bus.mtc0_we && !bus.exc_valid
                       && !bus.eret_valid && (bus.c0_sel == 3'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.exc_valid || bus.eret_valid) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im  <= '0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
            cause_bd   <= 1'b0;
            cause_exc  <= '0;
            cause_hw   <= '0;
            cause_sw   <= '0;
            epc        <= '0;
            badvaddr   <= '0;
            redirect_q <= '0;
        end else begin
            cause_hw <= bus.hw_int;
            if (exc_take) begin
                cause_exc  <= bus.exc_code[4:0];
                // A nested exception keeps the original return point.
                if (!status_exl) begin
                    epc      <= bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
                    cause_bd <= bus.exc_bd;
                end
                status_exl <= 1'b1;
                if (is_addr_err(bus.exc_code)) badvaddr <= bus.exc_badvaddr;
                redirect_q <= exc_vector(status_val[STATUS_BEV]);
            end else if (eret_take) begin
                status_exl <= 1'b0;
                redirect_q <= epc;
            end else if (mtc0_take) begin
                case (bus.c0_addr)
                    CP0_STATUS: begin
                        status_im  <= bus.mtc0_wdata[15:8];
                        status_exl <= bus.mtc0_wdata[1];
                        status_ie  <= bus.mtc0_wdata[0];
                    end
                    CP0_CAUSE: cause_sw <= bus.mtc0_wdata[9:8];
                    CP0_EPC:   epc      <= bus.mtc0_wdata;
                    default:   ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic count_we, compare_we;

    assign count_we   = mtc0_take && (bus.c0_addr == CP0_COUNT);
    assign compare_we = mtc0_take && (bus.c0_addr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (bus.mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    assign cause_ip   = {cause_hw[5] | ti, cause_hw[4:0], cause_sw};
    assign status_val = (STATUS_RESET & ~STATUS_WMASK)
                      | {16'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_val  = {cause_bd, ti, 14'b0, cause_ip, 1'b0, cause_exc, 2'b00};

    always_comb begin
        rdata = '0;
        if (bus.c0_sel == 3'd0) begin
            case (bus.c0_addr)
                CP0_BADVADDR: rdata = badvaddr;
                CP0_COUNT:    rdata = count;
                CP0_COMPARE:  rdata = compare;
                CP0_STATUS:   rdata = status_val;
                CP0_CAUSE:    rdata = cause_val;
                CP0_EPC:      rdata = epc;
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.mfc0_rdata  = rdata;
    assign bus.flush       = (state == ST_FLUSH);
    assign bus.redirect_pc = redirect_q;
    assign bus.int_pending = status_ie & ~status_exl & |(cause_ip & status_im);

endmodule
